sram_fifo_ctrl: RTL and testbench

//   Synchronous FIFO controller that drives the team's dual-port SRAM.

---
 rtl/sram_fifo_ctrl.sv | 91 +++++++++
 tb/tb_sram_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   Synchronous FIFO controller that sits in front of a dual-port SRAM with a
//   registered (1-cycle) read port. Generates the SRAM write/read strobes and
//   addresses, and presents a valid/ready push side plus a first-word-fall-
//   through pop side. The SRAM read register acts as the single output stage,
//   so total capacity is DEPTH+1 words.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   clr              synchronous flush: drops all queued words
//   s_valid/s_ready  push handshake, s_data is the pushed word
//   m_valid/m_ready  pop handshake, m_data is the SRAM read data
//   level            words held = SRAM occupancy + output stage
//   sram_*           SRAM write/read strobes, addresses and data
module sram_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int LW = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [LW-1:0]    level,
    output logic             sram_wren,
    output logic             sram_rden,
    output logic [AW-1:0]    sram_wr_addr,
    output logic [AW-1:0]    sram_rd_addr,
    output logic [WIDTH-1:0] sram_wr_data,
    input  logic [WIDTH-1:0] sram_rd_data
);

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] mem_count;
    logic          vld_q;

    // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2).
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Push acceptance depends only on registered state and clr, never on
    // m_ready. Gating with rstn keeps the SRAM untouched while in reset.
    assign s_ready   = rstn & (mem_count < CW'(DEPTH)) & ~clr;
    assign sram_wren = s_valid & s_ready;

    // A read is issued whenever the output stage is empty or being drained.
    // wptr==rptr only at mem_count 0 (no rden) or DEPTH (no wren), so the
    // SRAM never sees a same-address read and write in one cycle.
    assign sram_rden = rstn & (mem_count != '0) & (~vld_q | m_ready) & ~clr;

    assign sram_wr_addr = wptr;
    assign sram_rd_addr = rptr;
    assign sram_wr_data = s_data;
    assign m_data       = sram_rd_data;
    assign m_valid      = vld_q;
    assign level        = LW'(mem_count) + LW'(vld_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            vld_q     <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            vld_q     <= 1'b0;
        end else begin
            if (sram_wren) wptr <= ptr_inc(wptr);
            if (sram_rden) rptr <= ptr_inc(rptr);
            case ({sram_wren, sram_rden})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
            // A fresh read refills the output stage; otherwise a pop empties it.
            if (sram_rden)          vld_q <= 1'b1;
            else if (vld_q & m_ready) vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl
//   Directed bench: instance a (DEPTH=4) runs a table of per-cycle vectors
//   plus stall and mid-stream reset sequences; instance b (DEPTH=3) streams
//   100 words at full rate. Each instance drives a behavioural SRAM with a
//   registered read port that holds its output when rden is low.
module tb_sram_fifo_ctrl;

    localparam int W = 32;

    logic clk, rstn;
    int   ntest = 0;
    int   nfail = 0;

    // ---------------- instance a, DEPTH=4 ----------------
    logic         clr, s_valid, s_ready, m_valid, m_ready;
    logic [W-1:0] s_data, m_data, sram_wr_data, sram_rd_data;
    logic [2:0]   level;
    logic         sram_wren, sram_rden;
    logic [1:0]   sram_wr_addr, sram_rd_addr;
    logic [W-1:0] mem_a [4];

    sram_fifo_ctrl #(.WIDTH(W), .DEPTH(4)) u_dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .sram_wren(sram_wren), .sram_rden(sram_rden),
        .sram_wr_addr(sram_wr_addr), .sram_rd_addr(sram_rd_addr),
        .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
    );

    always @(posedge clk) begin
        if (sram_wren) mem_a[sram_wr_addr] <= sram_wr_data;
        if (sram_rden) sram_rd_data <= mem_a[sram_rd_addr];
    end

    // ---------------- instance b, DEPTH=3 ----------------
    logic         b_clr, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [W-1:0] b_s_data, b_m_data, b_wd, b_rd;
    logic [2:0]   b_level;
    logic         b_wren, b_rden;
    logic [1:0]   b_wa, b_ra;
    logic [W-1:0] mem_b [3];

    sram_fifo_ctrl #(.WIDTH(W), .DEPTH(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .clr(b_clr),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .level(b_level),
        .sram_wren(b_wren), .sram_rden(b_rden),
        .sram_wr_addr(b_wa), .sram_rd_addr(b_ra),
        .sram_wr_data(b_wd), .sram_rd_data(b_rd)
    );

    always @(posedge clk) begin
        if (b_wren) mem_b[b_wa] <= b_wd;
        if (b_rden) b_rd <= mem_b[b_ra];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same-address write+read and any SRAM access during reset are illegal.
    always @(posedge clk) begin
        if (rstn && sram_wren && sram_rden && sram_wr_addr == sram_rd_addr) begin
            nfail++;
            $display("FAIL collision_a: addr %0d written and read together", sram_wr_addr);
        end
        if (rstn && b_wren && b_rden && b_wa == b_ra) begin
            nfail++;
            $display("FAIL collision_b: addr %0d written and read together", b_wa);
        end
        if (!rstn && (sram_wren || sram_rden || b_wren || b_rden)) begin
            nfail++;
            $display("FAIL reset_access: got wren/rden %b%b %b%b, want 0000",
                     sram_wren, sram_rden, b_wren, b_rden);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         sv;
        logic [W-1:0] sd;
        logic         mr;
        logic         c;
        logic         sr, we, re, mv;
        logic [W-1:0] md;
        logic [2:0]   lvl;
        logic [1:0]   wa, ra;
    } vec_t;

    localparam int NV = 24;
    vec_t v [NV];

    function automatic vec_t mk(int sv, int sd, int mr, int c, int sr, int we, int re,
                                int mv, int md, int lvl, int wa, int ra);
        vec_t r;
        r.sv = sv[0]; r.sd = sd; r.mr = mr[0]; r.c = c[0];
        r.sr = sr[0]; r.we = we[0]; r.re = re[0]; r.mv = mv[0];
        r.md = md; r.lvl = 3'(lvl); r.wa = 2'(wa); r.ra = 2'(ra);
        return r;
    endfunction

    initial begin
        //          sv sd          mr clr  sr we re mv md          lvl wa ra
        // single word, empty FIFO, m_ready=1
        v[0]  = mk(1, 'hA5A50001, 1, 0,   1, 1, 0, 0, 0,          0,  0, 0);
        v[1]  = mk(0, 0,          1, 0,   1, 0, 1, 0, 0,          1,  1, 0);
        v[2]  = mk(0, 0,          1, 0,   1, 0, 0, 1, 'hA5A50001, 1,  1, 1);
        v[3]  = mk(0, 0,          0, 0,   1, 0, 0, 0, 0,          0,  1, 1);
        // push 1..6 with m_ready=0: 5 accepted, wptr wraps 3->0
        v[4]  = mk(1, 1,          0, 0,   1, 1, 0, 0, 0,          0,  1, 1);
        v[5]  = mk(1, 2,          0, 0,   1, 1, 1, 0, 0,          1,  2, 1);
        v[6]  = mk(1, 3,          0, 0,   1, 1, 0, 1, 1,          2,  3, 2);
        v[7]  = mk(1, 4,          0, 0,   1, 1, 0, 1, 1,          3,  0, 2);
        v[8]  = mk(1, 5,          0, 0,   1, 1, 0, 1, 1,          4,  1, 2);
        v[9]  = mk(1, 6,          0, 0,   0, 0, 0, 1, 1,          5,  2, 2);
        // drain 1..5
        v[10] = mk(0, 0,          1, 0,   0, 0, 1, 1, 1,          5,  2, 2);
        v[11] = mk(0, 0,          1, 0,   1, 0, 1, 1, 2,          4,  2, 3);
        v[12] = mk(0, 0,          1, 0,   1, 0, 1, 1, 3,          3,  2, 0);
        v[13] = mk(0, 0,          1, 0,   1, 0, 1, 1, 4,          2,  2, 1);
        v[14] = mk(0, 0,          1, 0,   1, 0, 0, 1, 5,          1,  2, 2);
        v[15] = mk(0, 0,          1, 0,   1, 0, 0, 0, 0,          0,  2, 2);
        // fill to level 3, clr with s_valid=1, then 0x77 round trip
        v[16] = mk(1, 'h11,       0, 0,   1, 1, 0, 0, 0,          0,  2, 2);
        v[17] = mk(1, 'h22,       0, 0,   1, 1, 1, 0, 0,          1,  3, 2);
        v[18] = mk(1, 'h33,       0, 0,   1, 1, 0, 1, 'h11,       2,  0, 3);
        v[19] = mk(1, 'h44,       0, 1,   0, 0, 0, 1, 'h11,       3,  1, 3);
        v[20] = mk(1, 'h77,       1, 0,   1, 1, 0, 0, 0,          0,  0, 0);
        v[21] = mk(0, 0,          1, 0,   1, 0, 1, 0, 0,          1,  1, 0);
        v[22] = mk(0, 0,          1, 0,   1, 0, 0, 1, 'h77,       1,  1, 1);
        v[23] = mk(0, 0,          0, 0,   1, 0, 0, 0, 0,          0,  1, 1);
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] expd [5];
        int n;

        rstn = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        b_clr = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_level",   level, 0);
        chk("rst_mvalid",  m_valid, 0);
        chk("rst_sready",  s_ready, 1);
        chk("rst_ptrs",    {sram_wr_addr, sram_rd_addr}, 0);

        // -------- table-driven vectors --------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            s_valid = v[i].sv; s_data = v[i].sd; m_ready = v[i].mr; clr = v[i].c;
            #1;
            ntest++;
            if ({s_ready, sram_wren, sram_rden, m_valid, level, sram_wr_addr, sram_rd_addr} !==
                {v[i].sr, v[i].we, v[i].re, v[i].mv, v[i].lvl, v[i].wa, v[i].ra} ||
                (v[i].mv && m_data !== v[i].md)) begin
                nfail++;
                $display("FAIL vec%0d: got sr,we,re,mv=%b%b%b%b lvl=%0d wa=%0d ra=%0d md=%h want sr,we,re,mv=%b%b%b%b lvl=%0d wa=%0d ra=%0d md=%h",
                         i, s_ready, sram_wren, sram_rden, m_valid, level, sram_wr_addr, sram_rd_addr, m_data,
                         v[i].sr, v[i].we, v[i].re, v[i].mv, v[i].lvl, v[i].wa, v[i].ra, v[i].md);
            end
        end
        @(negedge clk);
        clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0;

        // -------- stall: m_valid held 10 cycles with m_ready=0 --------
        s_valid = 1'b1; s_data = 'hB0;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 32'hC0 + i;
            #1;
            chk("stall_mvalid", m_valid, 1);
            chk("stall_mdata",  m_data, 'hB0);
            chk("stall_rden",   sram_rden, 0);
            chk("stall_wren",   sram_wren, (i < 4) ? 1 : 0);
            chk("stall_level",  level, 1 + ((i < 4) ? i : 4));
        end
        expd = '{32'hB0, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            s_valid = 1'b0; m_ready = 1'b1;
            #1;
            if (m_valid) begin
                if (n < 5) chk("drain_data", m_data, expd[n]);
                n++;
            end
        end
        chk("drain_count", n, 5);

        // -------- reset mid-stream at level 4 --------
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 32'hD0 + i;
        end
        @(negedge clk);
        #1;
        chk("pre_rst_level", level, 4);
        #2 rstn = 1'b0;
        #1;
        chk("in_rst_level",  level, 0);
        chk("in_rst_mvalid", m_valid, 0);
        chk("in_rst_sready", s_ready, 0);
        chk("in_rst_access", {sram_wren, sram_rden}, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1; s_valid = 1'b0;
        #1;
        chk("post_rst_sready", s_ready, 1);
        chk("post_rst_level",  level, 0);
        chk("post_rst_mvalid", m_valid, 0);

        // -------- DEPTH=3 full-rate stream of 0..99 --------
        begin
            int sent, got, nw, nr;
            bit started;
            sent = 0; got = 0; nw = 0; nr = 0; started = 1'b0;
            b_m_ready = 1'b1;
            for (int cyc = 0; cyc < 400 && got < 100; cyc++) begin
                @(negedge clk);
                b_s_valid = (sent < 100); b_s_data = sent;
                #1;
                if (b_wren) begin chk("stream_waddr", b_wa, nw % 3); nw++; end
                if (b_rden) begin chk("stream_raddr", b_ra, nr % 3); nr++; end
                if (b_level > 3'd2) chk("stream_level", b_level, 2);
                if (b_m_valid) begin
                    chk("stream_data", b_m_data, got);
                    got++;
                    started = 1'b1;
                end else if (started) begin
                    chk("stream_bubble", b_m_valid, 1);
                end
                if (b_wren) sent++;
            end
            chk("stream_count", got, 100);
            @(negedge clk);
            b_s_valid = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
